i2c_slave_rx: RTL and testbench

Single-byte write-receiver for the team's I2C-style serial link, sitting directly downstream of `i2c_master` on the shared open-drain `sda` line. It samples `sda` once per `clk` rising edge (one bit per cycle, no SCL) and detects a start bit. It then shifts in the slave address, drives ACK low when the address matches, and shifts in a data byte. After driving a second ACK, it checks the stop bit and presents the received byte to the local logic with a one-cycle valid strobe.

---
 rtl/i2c_slave_rx_if.sv | 23 ++
 rtl/i2c_slave_rx.sv | 178 +++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_rx_if.sv
// Local-side handshake between i2c_slave_rx and the logic that consumes received bytes.
interface i2c_slave_rx_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              addr_match;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  enable, address,
        output data_out, data_valid, addr_match, frame_err, busy
    );

    modport master (
        output enable, address,
        input  data_out, data_valid, addr_match, frame_err, busy
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// Single-byte write receiver on an open-drain, one-bit-per-clk serial line.
// Frame: start(0), address MSB first, ACK, data MSB first, ACK, stop(1).
module i2c_slave_rx #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    inout  wire            sda,
    i2c_slave_rx_if.slave  bus
);
    localparam int CNT_MAX = (ADDR_W > DATA_W + 2) ? ADDR_W : DATA_W + 2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_AD = 3'd2,
        DATA   = 3'd3,
        ACK_D  = 3'd4,
        STOP   = 3'd5,
        SKIP   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] own_q, own_d;
    logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
    logic [DATA_W-1:0] data_sr_q, data_sr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              drive_q, drive_d;
    logic              valid_q, valid_d;
    logic              match_q, match_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              sda_bit_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic [DATA_W-1:0] data_next_s;

    // Resolve the line: a floating (z) or unknown level reads as the pulled-up 1.
    always_comb begin
        if (sda == 1'b0) begin
            sda_bit_s = 1'b0;
        end else begin
            sda_bit_s = 1'b1;
        end
    end

    assign addr_next_s = ADDR_W'({addr_sr_q, sda_bit_s});
    assign data_next_s = DATA_W'({data_sr_q, sda_bit_s});

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        own_d      = own_q;
        addr_sr_d  = addr_sr_q;
        data_sr_d  = data_sr_q;
        data_out_d = data_out_q;
        drive_d    = drive_q;
        match_d    = match_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && !sda_bit_s) begin
                    own_d   = bus.address;
                    cnt_d   = '0;
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                addr_sr_d = addr_next_s;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                    if (addr_next_s == own_q) begin
                        match_d = 1'b1;
                        drive_d = 1'b1;
                        state_d = ACK_AD;
                    end else begin
                        cnt_d   = CNT_W'(DATA_W + 2);
                        state_d = SKIP;
                    end
                end else begin
                    state_d = ADDR;
                end
            end
            ACK_AD: begin
                drive_d = 1'b0;
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                data_sr_d = data_next_s;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    drive_d = 1'b1;
                    state_d = ACK_D;
                end else begin
                    state_d = DATA;
                end
            end
            ACK_D: begin
                drive_d = 1'b0;
                state_d = STOP;
            end
            STOP: begin
                if (sda_bit_s) begin
                    data_out_d = data_sr_q;
                    valid_d    = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                match_d = 1'b0;
                state_d = IDLE;
            end
            SKIP: begin
                // Count out the rest of a foreign frame, then judge only its stop bit.
                drive_d = 1'b0;
                if (cnt_q == '0) begin
                    if (!sda_bit_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                    end
                    match_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                drive_d = 1'b0;
                match_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            own_q      <= '0;
            addr_sr_q  <= '0;
            data_sr_q  <= '0;
            data_out_q <= '0;
            drive_q    <= 1'b0;
            valid_q    <= 1'b0;
            match_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            own_q      <= own_d;
            addr_sr_q  <= addr_sr_d;
            data_sr_q  <= data_sr_d;
            data_out_q <= data_out_d;
            drive_q    <= drive_d;
            valid_q    <= valid_d;
            match_q    <= match_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign sda            = drive_q ? 1'b0 : 1'bz;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = valid_q;
    assign bus.addr_match = match_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: directed frames from the test plan plus random frames,
// compared against a slot-by-slot timeline model of one frame.
module tb_i2c_slave_rx;
    logic clk = 1'b0;
    logic reset;
    logic m_oe;
    wire  sda;

    pullup pu_sda (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;

    i2c_slave_rx_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    i2c_slave_rx #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .sda   (sda),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_pulses = 0;
    int dv_times[$];
    logic [7:0] last_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) dv_times.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Bus idle (released) for n cycles; nothing may happen.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.enable = 1'b1;
            m_oe = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("idle_busy", bus.busy, 0);
            check("idle_dv", bus.data_valid, 0);
        end
    endtask

    // One 19-slot frame; slot s is sampled at edge k+s. Starts and ends at a negedge.
    task automatic run_frame(input logic en, input logic [6:0] own, input logic [6:0] abits,
                             input logic [7:0] data, input logic stop, input int abort_at);
        logic match;
        match = (abits == own);
        for (int s = 0; s < 19; s++) begin
            logic b;
            logic ack_slot;
            logic exp_sda;
            ack_slot = (s == 8) || (s == 17);
            if (s == 0) b = 1'b0;
            else if (s <= 7) b = abits[7 - s];
            else if (ack_slot) b = 1'b1;
            else if (s <= 16) b = data[16 - s];
            else b = stop;
            bus.enable  = en;
            bus.address = own;
            m_oe = ~b;
            #1;
            exp_sda = (ack_slot && en && match) ? 1'b0 : b;
            check("sda", sda, exp_sda);
            if (s == abort_at) begin
                reset = 1'b0;
                m_oe  = 1'b0;
                #1;
                last_data = 8'h00;
                check("rst_sda", sda, 1);
                check("rst_busy", bus.busy, 0);
                check("rst_am", bus.addr_match, 0);
                check("rst_dv", bus.data_valid, 0);
                check("rst_fe", bus.frame_err, 0);
                check("rst_dout", bus.data_out, 0);
                return;
            end
            @(posedge clk);
            @(negedge clk);
            check("busy", bus.busy, en && (s < 18));
            check("addr_match", bus.addr_match, en && match && (s >= 7) && (s < 18));
            check("data_valid", bus.data_valid, en && match && stop && (s == 18));
            check("frame_err", bus.frame_err, en && !stop && (s == 18));
            if (s == 18 && en && match && stop) begin
                last_data = data;
                exp_pulses++;
            end
            check("data_out", bus.data_out, last_data);
        end
    endtask

    initial begin
        int n0;
        reset = 1'b0;
        m_oe = 1'b0;
        bus.enable = 1'b0;
        bus.address = 7'h00;
        repeat (3) @(negedge clk);
        check("reset_sda", sda, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_am", bus.addr_match, 0);
        check("reset_dv", bus.data_valid, 0);
        check("reset_fe", bus.frame_err, 0);
        check("reset_dout", bus.data_out, 0);
        reset = 1'b1;
        idle(2);

        run_frame(1'b1, 7'h50, 7'h50, 8'hA5, 1'b1, -1);
        idle(1);
        run_frame(1'b1, 7'h50, 7'h51, 8'hA5, 1'b1, -1);
        idle(1);
        run_frame(1'b1, 7'h50, 7'h50, 8'h5A, 1'b0, -1);
        idle(1);
        run_frame(1'b1, 7'h50, 7'h50, 8'h77, 1'b1, 8);
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        run_frame(1'b1, 7'h50, 7'h50, 8'h96, 1'b1, -1);

        n0 = dv_times.size();
        run_frame(1'b1, 7'h50, 7'h50, 8'h3C, 1'b1, -1);
        run_frame(1'b1, 7'h50, 7'h50, 8'hC3, 1'b1, -1);
        if (dv_times.size() >= n0 + 2) check("b2b_gap", dv_times[n0 + 1] - dv_times[n0], 19);
        else check("b2b_count", dv_times.size(), n0 + 2);
        idle(1);

        run_frame(1'b0, 7'h50, 7'h50, 8'hA5, 1'b1, -1);
        idle(1);

        for (int i = 0; i < 24; i++) begin
            logic [6:0] own;
            logic [6:0] abits;
            logic [7:0] data;
            logic stop;
            logic en;
            int gap;
            own   = 7'($urandom_range(0, 127));
            abits = ($urandom_range(0, 3) != 0) ? own : 7'($urandom_range(0, 127));
            data  = 8'($urandom_range(0, 255));
            stop  = ($urandom_range(0, 4) != 0);
            en    = ($urandom_range(0, 5) != 0);
            gap   = $urandom_range(0, 2);
            run_frame(en, own, abits, data, stop, -1);
            if (gap > 0) idle(gap);
        end
        idle(2);
        check("pulse_count", dv_times.size(), exp_pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
